// File: rtl/pong_gfx_pkg.sv
// Pong graphics package: VGA 640x480 timing defaults, 12-bit RGB
// palette, flash FSM encoding and the stage-1 hit bundle.
package pong_gfx_pkg;

  localparam int VGA_H_OFFSET = 144;
  localparam int VGA_V_OFFSET = 35;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  localparam logic [11:0] COL_WHITE = 12'hFFF;
  localparam logic [11:0] COL_GREY  = 12'h888;
  localparam logic [11:0] COL_P1    = 12'hF00;
  localparam logic [11:0] COL_P2    = 12'h00F;
  localparam logic [11:0] COL_BLACK = 12'h000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } gfx_state_e;

  typedef struct packed {
    logic active;
    logic flag;
    logic ball;
    logic pad1;
    logic pad2;
    logic line;
    logic border;
  } s1_t;

endpackage

// File: rtl/pong_span_hit.sv
// Half-open rectangle test: hit when x in [x0,x0+w) and y in [y0,y0+h).
// Ports: x_i/y_i pixel, x0_i/y0_i origin, w_i/h_i size, hit_o result.
module pong_span_hit #(
  parameter int COORD_W = 12
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic               hit_o
);

  // one extra bit so an object near the top of the range clips
  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, x0_i} + {1'b0, w_i};
  assign y_end = {1'b0, y0_i} + {1'b0, h_i};

  assign hit_o = (x_i >= x0_i) && ({1'b0, x_i} < x_end) &&
                 (y_i >= y0_i) && ({1'b0, y_i} < y_end);

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong pixel renderer: 2-stage pix_en pipeline from raw VGA counters
// to RGB, with layered objects and a goal-flash border FSM.
// Ports: clk/rst, pix_en_i strobe, h/v_cnt_i counters, paddle/ball
// coordinates, flag_i enable, goal_pulse_i/scorer_i goal event;
// red/green/blue_o registered colour, flashing_o FSM status.
module pong_frame_renderer
  import pong_gfx_pkg::*;
#(
  parameter int COORD_W      = 12,
  parameter int COLOR_W      = 4,
  parameter int H_OFFSET     = VGA_H_OFFSET,
  parameter int V_OFFSET     = VGA_V_OFFSET,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int BORDER       = 10,
  parameter int LINE_W       = 10,
  parameter int DASH_LEN     = 16,
  parameter int PADDLE_LEN   = 50,
  parameter int PADDLE_THICK = 10,
  parameter int PADDLE_INSET = 40,
  parameter int BALL_SIDE    = 10,
  parameter int FLASH_FRAMES = 60,
  parameter int BLINK_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en_i,
  input  logic [COORD_W-1:0] h_cnt_i,
  input  logic [COORD_W-1:0] v_cnt_i,
  input  logic [COORD_W-1:0] paddle1_y_i,
  input  logic [COORD_W-1:0] paddle2_y_i,
  input  logic [COORD_W-1:0] ball_x_i,
  input  logic [COORD_W-1:0] ball_y_i,
  input  logic               flag_i,
  input  logic               goal_pulse_i,
  input  logic               scorer_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               flashing_o
);

  typedef logic [COORD_W-1:0] crd_t;
  typedef logic [COORD_W:0]   crd1_t;

  localparam crd_t  HOFF    = crd_t'(H_OFFSET);
  localparam crd_t  VOFF    = crd_t'(V_OFFSET);
  localparam crd1_t H_END   = crd1_t'(H_OFFSET + H_ACTIVE);
  localparam crd1_t V_END   = crd1_t'(V_OFFSET + V_ACTIVE);
  localparam crd_t  BRD     = crd_t'(BORDER);
  localparam crd_t  BRD_R   = crd_t'(H_ACTIVE - BORDER);
  localparam crd_t  BRD_B   = crd_t'(V_ACTIVE - BORDER);
  localparam crd_t  LINE_LO = crd_t'(H_ACTIVE / 2 - LINE_W / 2);
  localparam crd1_t LINE_HI = crd1_t'(H_ACTIVE / 2 - LINE_W / 2 + LINE_W);
  localparam crd_t  P1_X    = crd_t'(PADDLE_INSET);
  localparam crd_t  P2_X    = crd_t'(H_ACTIVE - PADDLE_INSET - PADDLE_THICK);
  localparam crd_t  P_THK   = crd_t'(PADDLE_THICK);
  localparam crd_t  P_LEN   = crd_t'(PADDLE_LEN);
  localparam crd_t  B_SIDE  = crd_t'(BALL_SIDE);

  localparam int FRAME_W = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FLASH_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  // ---------------- stage 1: geometry ----------------
  crd_t x;
  crd_t y;
  logic act_h;
  logic act_v;
  logic line_x;
  logic dash_ok;
  logic ball_hit;
  logic pad1_hit;
  logic pad2_hit;
  s1_t  s1_d;
  s1_t  s1_q;

  assign x = h_cnt_i - HOFF;
  assign y = v_cnt_i - VOFF;

  assign act_h  = (h_cnt_i >= HOFF) && ({1'b0, h_cnt_i} < H_END);
  assign act_v  = (v_cnt_i >= VOFF) && ({1'b0, v_cnt_i} < V_END);
  assign line_x = (x >= LINE_LO) && ({1'b0, x} < LINE_HI);

  generate
    if (DASH_LEN > 0) begin : g_dash
      localparam crd_t DL = crd_t'(DASH_LEN);
      // dash visible on even periods of DASH_LEN lines
      assign dash_ok = ((y / DL) & crd_t'(1)) == '0;
    end else begin : g_solid
      assign dash_ok = 1'b1;
    end
  endgenerate

  pong_span_hit #(.COORD_W(COORD_W)) u_ball (
    .x_i  (x),
    .y_i  (y),
    .x0_i (ball_x_i),
    .y0_i (ball_y_i),
    .w_i  (B_SIDE),
    .h_i  (B_SIDE),
    .hit_o(ball_hit)
  );

  pong_span_hit #(.COORD_W(COORD_W)) u_pad1 (
    .x_i  (x),
    .y_i  (y),
    .x0_i (P1_X),
    .y0_i (paddle1_y_i),
    .w_i  (P_THK),
    .h_i  (P_LEN),
    .hit_o(pad1_hit)
  );

  pong_span_hit #(.COORD_W(COORD_W)) u_pad2 (
    .x_i  (x),
    .y_i  (y),
    .x0_i (P2_X),
    .y0_i (paddle2_y_i),
    .w_i  (P_THK),
    .h_i  (P_LEN),
    .hit_o(pad2_hit)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.active = act_h & act_v;
    s1_d.flag   = flag_i;
    s1_d.ball   = ball_hit;
    s1_d.pad1   = pad1_hit;
    s1_d.pad2   = pad2_hit;
    s1_d.line   = line_x & dash_ok;
    s1_d.border = (x < BRD) || (x >= BRD_R) ||
                  (y < BRD) || (y >= BRD_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (pix_en_i) begin
      s1_q <= s1_d;
    end
  end

  // ---------------- goal-flash FSM ----------------
  gfx_state_e         state_q;
  logic               flashing_q;
  logic               scorer_q;
  logic               phase_on_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic [BLINK_W-1:0] blink_q;
  logic [BLINK_W-1:0] blink_d;
  logic               tick;

  assign tick    = (h_cnt_i == '0) && (v_cnt_i == '0);
  assign frame_d = frame_q + FRAME_W'(1);
  assign blink_d = blink_q + BLINK_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flashing_q <= 1'b0;
      scorer_q   <= 1'b0;
      phase_on_q <= 1'b0;
      frame_q    <= '0;
      blink_q    <= '0;
    end else if (pix_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (goal_pulse_i) begin
            state_q    <= ST_FLASH;
            flashing_q <= 1'b1;
            scorer_q   <= scorer_i;
            phase_on_q <= 1'b1;
            frame_q    <= '0;
            blink_q    <= '0;
          end
        end
        ST_FLASH: begin
          // a new goal outranks the final-frame exit
          if (goal_pulse_i) begin
            flashing_q <= 1'b1;
            scorer_q   <= scorer_i;
            phase_on_q <= 1'b1;
            frame_q    <= '0;
            blink_q    <= '0;
          end else if (tick) begin
            if (frame_d == FRAME_LAST) begin
              state_q    <= ST_IDLE;
              flashing_q <= 1'b0;
              phase_on_q <= 1'b0;
              frame_q    <= '0;
              blink_q    <= '0;
            end else begin
              frame_q <= frame_d;
              if (blink_q == BLINK_LAST) begin
                blink_q    <= '0;
                phase_on_q <= ~phase_on_q;
              end else begin
                blink_q <= blink_d;
              end
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          flashing_q <= 1'b0;
        end
      endcase
    end
  end

  assign flashing_o = flashing_q;

  // ---------------- stage 2: priority mux ----------------
  logic [11:0] border_col;
  logic [11:0] pix_col;
  logic [11:0] rgb_q;

  always_comb begin
    border_col = COL_WHITE;
    if (state_q == ST_FLASH && phase_on_q) begin
      border_col = scorer_q ? COL_P2 : COL_P1;
    end
    pix_col = COL_BLACK;
    if (s1_q.active && s1_q.flag) begin
      if (s1_q.ball) begin
        pix_col = COL_WHITE;
      end else if (s1_q.pad1) begin
        pix_col = COL_P1;
      end else if (s1_q.pad2) begin
        pix_col = COL_P2;
      end else if (s1_q.line) begin
        pix_col = COL_GREY;
      end else if (s1_q.border) begin
        pix_col = border_col;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (pix_en_i) begin
      rgb_q <= pix_col;
    end
  end

  // widen each 4-bit channel by repeating its bits from the MSB down
  for (genvar k = 0; k < COLOR_W; k++) begin : g_scale
    assign red_o[COLOR_W-1-k]   = rgb_q[11 - (k % 4)];
    assign green_o[COLOR_W-1-k] = rgb_q[7 - (k % 4)];
    assign blue_o[COLOR_W-1-k]  = rgb_q[3 - (k % 4)];
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Scoreboard bench for pong_frame_renderer: a reference model predicts
// each strobe's colour, a monitor compares on every clock.
module tb_pong_frame_renderer;

  localparam int HO = 144;
  localparam int VO = 35;
  localparam int FLASH_FRAMES = 60;
  localparam int BLINK_FRAMES = 8;

  localparam logic [11:0] C_WHITE = 12'hFFF;
  localparam logic [11:0] C_GREY  = 12'h888;
  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_BLUE  = 12'h00F;

  localparam int K_BLACK  = 0;
  localparam int K_WHITE  = 1;
  localparam int K_GREY   = 2;
  localparam int K_P1     = 3;
  localparam int K_P2     = 4;
  localparam int K_BORDER = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [11:0] h_cnt = '0;
  logic [11:0] v_cnt = '0;
  logic [11:0] p1y = '0;
  logic [11:0] p2y = '0;
  logic [11:0] bx = '0;
  logic [11:0] by = '0;
  logic        flag = 1'b0;
  logic        goal = 1'b0;
  logic        scorer = 1'b0;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        flashing;

  always #5 clk = ~clk;

  pong_frame_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en_i    (pix_en),
    .h_cnt_i     (h_cnt),
    .v_cnt_i     (v_cnt),
    .paddle1_y_i (p1y),
    .paddle2_y_i (p2y),
    .ball_x_i    (bx),
    .ball_y_i    (by),
    .flag_i      (flag),
    .goal_pulse_i(goal),
    .scorer_i    (scorer),
    .red_o       (red),
    .green_o     (green),
    .blue_o      (blue),
    .flashing_o  (flashing)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state
  int pend = K_BLACK;
  bit m_fl = 1'b0;
  int m_cnt = 0;
  bit m_sc = 1'b0;

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_span(input int v, input int lo, input int n);
    return (v >= lo) && (v < lo + n);
  endfunction

  function automatic int kind_of(input int h, input int v, input int a1,
                                 input int a2, input int x0, input int y0,
                                 input bit f);
    int x;
    int y;
    x = h - HO;
    y = v - VO;
    if (!f || x < 0 || x >= 640 || y < 0 || y >= 480) return K_BLACK;
    if (in_span(x, x0, 10) && in_span(y, y0, 10)) return K_WHITE;
    if (in_span(x, 40, 10) && in_span(y, a1, 50)) return K_P1;
    if (in_span(x, 590, 10) && in_span(y, a2, 50)) return K_P2;
    if (in_span(x, 315, 10) && ((y / 16) % 2 == 0)) return K_GREY;
    if (x < 10 || x >= 630 || y < 10 || y >= 470) return K_BORDER;
    return K_BLACK;
  endfunction

  function automatic logic [11:0] resolve(input int k);
    case (k)
      K_WHITE: return C_WHITE;
      K_GREY:  return C_GREY;
      K_P1:    return C_RED;
      K_P2:    return C_BLUE;
      K_BORDER: begin
        if (m_fl && ((m_cnt / BLINK_FRAMES) % 2 == 0))
          return m_sc ? C_BLUE : C_RED;
        return C_WHITE;
      end
      default: return 12'h000;
    endcase
  endfunction

  // one clock of stimulus; on a strobe the expected output of that
  // edge (the previous strobe's pixel) is queued
  task automatic step(input int h, input int v, input bit pe, input bit g,
                      input bit sc, input bit f);
    exp_t e;
    @(negedge clk);
    h_cnt  = 12'(h);
    v_cnt  = 12'(v);
    pix_en = pe;
    goal   = g;
    scorer = sc;
    flag   = f;
    if (pe) begin
      e.rgb = resolve(pend);
      if (g) begin
        m_fl  = 1'b1;
        m_cnt = 0;
        m_sc  = sc;
      end else if (h == 0 && v == 0 && m_fl) begin
        m_cnt++;
        if (m_cnt == FLASH_FRAMES - 1) m_fl = 1'b0;
      end
      e.fl = m_fl;
      exp_q.push_back(e);
      pend = kind_of(h, v, int'(p1y), int'(p2y), int'(bx), int'(by), f);
    end
  endtask

  task automatic set_obj(input int a1, input int a2, input int x0,
                         input int y0);
    @(negedge clk);
    pix_en = 1'b0;
    goal   = 1'b0;
    p1y    = 12'(a1);
    p2y    = 12'(a2);
    bx     = 12'(x0);
    by     = 12'(y0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    last.rgb = '0;
    last.fl  = 1'b0;
    pend     = K_BLACK;
    m_fl     = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    rst    = 1'b1;
    pix_en = 1'b0;
    goal   = 1'b0;
    #1;
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_flashing", {11'b0, flashing}, 12'h000);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one frame of the flash: tick, then a border pixel shown in full
  task automatic flash_frame(input int k, input logic [11:0] col);
    step(0, 0, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    chk($sformatf("flash_flag_f%0d", k), {11'b0, flashing},
        (k < FLASH_FRAMES - 1) ? 12'h001 : 12'h000);
    step(HO, VO, 1, 0, 0, 1);
    step(HO + 56, VO + 5, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    if (k < 16)
      chk($sformatf("flash_border_f%0d", k), {red, green, blue},
          (k < BLINK_FRAMES) ? col : C_WHITE);
  endtask

  task automatic goal_evt(input bit sc, input logic [11:0] col);
    step(1, 1, 1, 1, sc, 1);
    @(posedge clk);
    #1;
    chk("goal_flashing", {11'b0, flashing}, 12'h001);
    step(HO, VO, 1, 0, 0, 1);
    step(HO + 1, VO + 1, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("goal_border_f0", {red, green, blue}, col);
  endtask

  function automatic int rnd_coord(input int hi);
    if ($urandom_range(0, 9) == 0) return $urandom_range(4086, 4095);
    return $urandom_range(0, hi);
  endfunction

  // monitor: pops one expectation per strobe, otherwise output must hold
  initial begin
    bit s;
    bit r;
    last.rgb = '0;
    last.fl  = 1'b0;
    forever begin
      @(posedge clk);
      s = pix_en;
      r = rst;
      #1;
      if (!r && !rst) begin
        if (s) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue expected entry");
          end else begin
            last = exp_q.pop_front();
          end
        end
        chk("sb_rgb", {red, green, blue}, last.rgb);
        chk("sb_flashing", {11'b0, flashing}, {11'b0, last.fl});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h;
    int v;
    int r;
    bit pe;
    repeat (3) @(negedge clk);
    chk("reset_rgb", {red, green, blue}, 12'h000);
    chk("reset_flashing", {11'b0, flashing}, 12'h000);
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // ball edges
    set_obj(300, 300, 100, 200);
    step(244, 235, 1, 0, 0, 1);
    step(254, 235, 1, 0, 0, 1);
    step(253, 244, 1, 0, 0, 1);
    step(244, 245, 1, 0, 0, 1);
    // paddle over border, ball over paddle
    set_obj(0, 300, 500, 400);
    step(184, 35, 1, 0, 0, 1);
    step(HO + 595, VO + 320, 1, 0, 0, 1);
    set_obj(0, 300, 40, 0);
    step(184, 35, 1, 0, 0, 1);
    step(193, 84, 1, 0, 0, 1);
    step(194, 85, 1, 0, 0, 1);
    // flag off, then a stall
    set_obj(200, 200, 500, 400);
    step(HO, VO, 1, 0, 0, 0);
    step(HO, VO, 1, 0, 0, 1);
    repeat (5) step(HO + 320, VO + 100, 0, 0, 0, 1);
    step(HO + 320, VO + 100, 1, 0, 0, 1);
    // dashed serving line
    for (int y = 0; y < 32; y++) step(HO + 320, VO + y, 1, 0, 0, 1);
    step(HO + 314, VO + 40, 1, 0, 0, 1);
    step(HO + 325, VO + 40, 1, 0, 0, 1);

    // full flash, scorer 2
    goal_evt(1'b1, C_BLUE);
    for (int k = 1; k <= FLASH_FRAMES; k++) flash_frame(k, C_BLUE);
    // restart at frame 30
    goal_evt(1'b1, C_BLUE);
    for (int k = 1; k <= 30; k++) flash_frame(k, C_BLUE);
    goal_evt(1'b0, C_RED);
    for (int k = 1; k <= FLASH_FRAMES; k++) flash_frame(k, C_RED);
    // goal on the final tick wins over exit
    goal_evt(1'b1, C_BLUE);
    for (int k = 1; k < FLASH_FRAMES - 1; k++) flash_frame(k, C_BLUE);
    step(0, 0, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    chk("restart_on_exit", {11'b0, flashing}, 12'h001);
    for (int k = 1; k < 4; k++) flash_frame(k, C_RED);
    // reset mid-flash
    step(HO, VO, 1, 0, 0, 1);
    step(HO + 1, VO, 1, 0, 0, 1);
    async_rst();
    step(244, 235, 1, 0, 0, 1);
    step(HO, VO, 1, 0, 0, 1);
    step(HO + 1, VO, 1, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        set_obj(rnd_coord(480), rnd_coord(480), rnd_coord(650),
                rnd_coord(490));
      r = $urandom_range(0, 99);
      if (r < 3) begin
        h = 0;
        v = 0;
      end else if (r < 40) begin
        h = int'(bx) + HO + $urandom_range(0, 14) - 3;
        v = int'(by) + VO + $urandom_range(0, 14) - 3;
      end else if (r < 55) begin
        h = HO + 37 + $urandom_range(0, 15);
        v = int'(p1y) + VO + $urandom_range(0, 56) - 3;
      end else if (r < 70) begin
        h = HO + 587 + $urandom_range(0, 15);
        v = int'(p2y) + VO + $urandom_range(0, 56) - 3;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      if (h < 0 || h > 4095) h = 1;
      if (v < 0 || v > 4095) v = 1;
      pe = ($urandom_range(0, 9) < 7);
      step(h, v, pe, ($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0));
    end

    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    chk("sb_drain", 12'(exp_q.size()), 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
